// File: rtl/uart_pkg.sv
// Shared UART RX definitions: FSM request codes, data-width limits and code decoding.
package uart_pkg;

  localparam logic [3:0] CTRL_HUNT   = 4'b0000;
  localparam logic [3:0] CTRL_START  = 4'b0001;
  localparam logic [3:0] CTRL_DATA   = 4'b0010;
  localparam logic [3:0] CTRL_PARITY = 4'b0100;
  localparam logic [3:0] CTRL_STOP0  = 4'b1000;
  localparam logic [3:0] CTRL_STOP1  = 4'b1001;

  localparam logic [3:0] DATA_MIN = 4'd5;
  localparam logic [3:0] DATA_MAX = 4'd8;

  typedef enum logic [2:0] {
    STG_HUNT,
    STG_START,
    STG_DATA,
    STG_PARITY,
    STG_STOP0,
    STG_STOP1
  } stage_e;

  // Unlisted request codes all mean "hunt for a start edge".
  function automatic stage_e decodeStage(input logic [3:0] code);
    case (code)
      CTRL_START:  return STG_START;
      CTRL_DATA:   return STG_DATA;
      CTRL_PARITY: return STG_PARITY;
      CTRL_STOP0:  return STG_STOP0;
      CTRL_STOP1:  return STG_STOP1;
      default:     return STG_HUNT;
    endcase
  endfunction

  function automatic logic [3:0] clampWidth(input logic [3:0] n);
    if (n < DATA_MIN)      return DATA_MIN;
    else if (n > DATA_MAX) return DATA_MAX;
    else                   return n;
  endfunction

endpackage

// File: rtl/rx_line_sync.sv
// Serial line synchronizer with falling-edge detect.
// With RX_MAJORITY_VOTE_EN defined it also keeps a tick-rate history for 2-of-3 voting.
module rx_line_sync (
  input  logic PCLK,
  input  logic PRESETn,
`ifdef RX_MAJORITY_VOTE_EN
  input  logic i_sampleTick,
`endif
  input  logic i_rxd,
  output logic o_fall,
  output logic o_sampleBit
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Idle-high reset so a line held low through reset never looks like a start edge.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rxd;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_fall = r_prev & ~r_sync;

`ifdef RX_MAJORITY_VOTE_EN
  logic [1:0] r_hist;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)          r_hist <= 2'b11;
    else if (i_sampleTick) r_hist <= {r_hist[0], r_sync};
  end

  // The two previous ticks plus the current one.
  assign o_sampleBit = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_sync) | (r_hist[0] & r_sync);
`else
  assign o_sampleBit = r_sync;
`endif

endmodule

// File: rtl/rx_shift_register.sv
// UART RX oversampling front end: start detect, mid-bit sampling, data/parity/stop checks.
// Optional RX_MAJORITY_VOTE_EN selects 2-of-3 voting around the mid-bit sample point.
module rx_shift_register
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int MAX_DATA   = 8
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                sample_tick,
  input  logic                rxd,
  input  logic [3:0]          ctrl_shift_register,
  input  logic [3:0]          number_data_receive,
  input  logic                parity_odd,
  input  logic                ctrl_rx_buffer,
  output logic                data_is_avail,
  output logic                start_bit,
  output logic                data_is_received,
  output logic                parity_bit,
  output logic                stop_bit,
  output logic [MAX_DATA-1:0] rx_data
);

  localparam int PW = $clog2(OVERSAMPLE);
  localparam int CW = $clog2(MAX_DATA + 1);
`ifdef RX_MAJORITY_VOTE_EN
  localparam logic [PW-1:0] SAMPLE_PH = PW'(OVERSAMPLE / 2);
`else
  localparam logic [PW-1:0] SAMPLE_PH = PW'(OVERSAMPLE / 2 - 1);
`endif

  logic                w_fall;
  logic                w_bit;
  logic                w_samplePoint;
  stage_e              w_stage;
  logic [3:0]          w_n;
  logic [CW-1:0]       w_shamt;

  logic [PW-1:0]       r_ph;
  logic [3:0]          r_prevCode;
  logic [3:0]          r_bitCnt;
  logic [MAX_DATA-1:0] r_shift;
  logic [MAX_DATA-1:0] r_rxData;
  logic                r_parity;
  logic                r_dataAvail;
  logic                r_startBit;
  logic                r_dataRcvd;
  logic                r_parityBit;
  logic                r_stopBit;

  rx_line_sync u_sync (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
`ifdef RX_MAJORITY_VOTE_EN
    .i_sampleTick(sample_tick),
`endif
    .i_rxd       (rxd),
    .o_fall      (w_fall),
    .o_sampleBit (w_bit)
  );

  assign w_stage       = decodeStage(ctrl_shift_register);
  assign w_n           = clampWidth(number_data_receive);
  assign w_shamt       = CW'(MAX_DATA) - CW'(w_n);
  assign w_samplePoint = sample_tick && (r_ph == SAMPLE_PH);

  // Bit timing is anchored to the start edge and free-runs across every stage.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                        r_ph <= '0;
    else if (w_stage == STG_HUNT && w_fall) r_ph <= '0;
    else if (sample_tick)                r_ph <= r_ph + 1'b1;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_prevCode  <= CTRL_HUNT;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_rxData    <= '0;
      r_parity    <= 1'b0;
      r_dataAvail <= 1'b0;
      r_startBit  <= 1'b0;
      r_dataRcvd  <= 1'b0;
      r_parityBit <= 1'b0;
      r_stopBit   <= 1'b0;
    end else begin
      r_prevCode <= ctrl_shift_register;
      // Reads the shifter before any same-cycle hunt clear takes effect.
      if (ctrl_rx_buffer) r_rxData <= r_shift >> w_shamt;

      case (w_stage)
        STG_START: begin
          r_dataRcvd  <= 1'b0;
          r_parityBit <= 1'b0;
          r_stopBit   <= 1'b0;
          if (w_samplePoint) begin
            r_startBit <= ~w_bit;
            if (w_bit) r_dataAvail <= 1'b0;
          end
        end
        STG_DATA: begin
          r_startBit  <= 1'b0;
          r_parityBit <= 1'b0;
          r_stopBit   <= 1'b0;
          if (w_samplePoint && (r_bitCnt < w_n)) begin
            r_shift  <= {w_bit, r_shift[MAX_DATA-1:1]};
            r_parity <= r_parity ^ w_bit;
            r_bitCnt <= r_bitCnt + 4'd1;
            if (r_bitCnt + 4'd1 == w_n) r_dataRcvd <= 1'b1;
          end
        end
        STG_PARITY: begin
          r_startBit <= 1'b0;
          r_dataRcvd <= 1'b0;
          r_stopBit  <= 1'b0;
          if (w_samplePoint) r_parityBit <= ((w_bit ^ r_parity) == parity_odd);
        end
        STG_STOP0, STG_STOP1: begin
          r_startBit  <= 1'b0;
          r_dataRcvd  <= 1'b0;
          r_parityBit <= 1'b0;
          if (w_samplePoint)
            r_stopBit <= w_bit;
          else if (w_stage == STG_STOP1 && r_prevCode != CTRL_STOP1)
            r_stopBit <= 1'b0;
        end
        default: begin
          r_startBit  <= 1'b0;
          r_dataRcvd  <= 1'b0;
          r_parityBit <= 1'b0;
          r_stopBit   <= 1'b0;
          r_bitCnt    <= '0;
          r_shift     <= '0;
          r_parity    <= 1'b0;
          if (w_fall)
            r_dataAvail <= 1'b1;
          else if (decodeStage(r_prevCode) != STG_HUNT)
            r_dataAvail <= 1'b0;
        end
      endcase
    end
  end

  assign data_is_avail    = r_dataAvail;
  assign start_bit        = r_startBit;
  assign data_is_received = r_dataRcvd;
  assign parity_bit       = r_parityBit;
  assign stop_bit         = r_stopBit;
  assign rx_data          = r_rxData;

endmodule

// File: doc/rx_shift_register.md
# rx_shift_register

Oversampling receive front end for the UART RX path. Synchronizes the serial line, detects the start edge, and samples each bit at mid-bit using a 16x oversample enable. It assembles 5–8 data bits LSB first and checks parity and stop bits. It reports each stage as a level flag to the RX FSM, which steps it with the `ctrl_shift_register` request code. The FSM's `ctrl_rx_buffer` strobe captures the assembled word for the RX buffer.

## Interface
- `OVERSAMPLE`, default 16: sample ticks per bit (power of two, ≥8).
- `MAX_DATA`, default 8: widest data field and width of `rx_data`.

Ports:
- `PCLK` in 1: system clock.
- `PRESETn` in 1: reset, asynchronous, active-low.
- `sample_tick` in 1: one-PCLK enable, OVERSAMPLE per bit period.
- `rxd` in 1: asynchronous serial line, idle high.
- `ctrl_shift_register` in 4: request code from the FSM. 0001 = start, 0010 = data, 0100 = parity, 1000 = stop0, 1001 = stop1. Any other value = hunt.
- `number_data_receive` in 4: data bits per frame.
- `parity_odd` in 1: 1 = odd parity expected, 0 = even.
- `ctrl_rx_buffer` in 1: capture strobe.
- `data_is_avail` out 1: start edge detected, frame in progress.
- `start_bit` out 1: start bit confirmed low at mid-bit.
- `data_is_received` out 1: all data bits sampled.
- `parity_bit` out 1: sampled parity matches expected.
- `stop_bit` out 1: current stop bit sampled high.
- `rx_data` out MAX_DATA: captured word, right-aligned, upper bits zero.

## Operation
- `rxd` passes through a 2-flop synchronizer that resets to 1. `rxd_s` denotes the synchronized value.
- Phase counter `ph` (log2 OVERSAMPLE bits):
  - Cleared on start-edge detection.
  - Increments on each `sample_tick` and wraps at OVERSAMPLE−1.
  - The sample point is `ph == OVERSAMPLE/2−1`, i.e. the 8th tick.
- Effective width: N = 5 if `number_data_receive` < 5, 8 if it is > 8, otherwise its value.
- Hunt (any unlisted code):
  - Clears all flags, the bit counter and the data shifter.
  - A 1→0 transition of `rxd_s` sets `data_is_avail` and clears `ph`.
  - `data_is_avail` holds until the code returns to hunt after a frame, or until a false start.
- Start (0001), at the sample point:
  - `rxd_s` = 0 sets `start_bit`.
  - `rxd_s` = 1 is a false start: clear `data_is_avail` and re-arm the hunt.
- Data (0010):
  - At each sample point, shift `rxd_s` into the MSB side of the shifter and increment the bit counter.
  - After the Nth sample, set `data_is_received` and take no further samples.
  - Running parity is the XOR of the data bits.
- Parity (0100): at the sample point, `parity_bit` = (`rxd_s` XOR running parity) equals `parity_odd`.
- Stop0 (1000) / stop1 (1001): at the sample point, `stop_bit` = `rxd_s`. Entry into stop1 clears `stop_bit` before sampling the second stop bit.
- Code change:
  - Clears the flag of the previous stage on the next PCLK.
  - Does not disturb `ph`; bit timing stays continuous from the start edge.
- `ctrl_rx_buffer` high loads `rx_data` with the shifter right-aligned: shifter >> (MAX_DATA−N), zero-extended.
- Break (line low at stop): `stop_bit` stays 0. The FSM flags the error.

## Timing
- Reset value of every output is 0, including `rx_data`. The synchronizer resets to 1, `ph` and the counters to 0.
- `rxd` to `rxd_s`: 2 PCLK.
- Edge to `data_is_avail`: 1 PCLK after the `rxd_s` fall.
- Flags rise 1 PCLK after the `sample_tick` at the sample point. They are levels, held until the code changes.
- Sample and code change on the same PCLK: the change wins, and the sample applies to the new stage only if the new code uses it.
- `rx_data` updates 1 PCLK after `ctrl_rx_buffer`. Capture and a hunt clear on the same cycle: capture uses the pre-clear shifter.
- `PRESETn` assertion mid-frame: immediate return to hunt, all outputs 0.

## Configuration
- `RX_MAJORITY_VOTE_EN` defined: the sampled bit is the 2-of-3 majority of `rxd_s` at ticks OVERSAMPLE/2−2, −1 and 0. The flag still updates at the third of these ticks.
- `RX_MAJORITY_VOTE_EN` undefined: a single sample at OVERSAMPLE/2−1.

## Structure
- `uart_pkg` holds:
  - the ctrl code localparams (`CTRL_HUNT`, `CTRL_START`, `CTRL_DATA`, `CTRL_PARITY`, `CTRL_STOP0`, `CTRL_STOP1`);
  - the constants `DATA_MIN` = 5 and `DATA_MAX` = 8.
- Sub-module `rx_line_sync`: the 2-flop synchronizer plus falling-edge detect. It also holds the 3-sample history used under `RX_MAJORITY_VOTE_EN`.

## Test plan
- Valid 8N1 frame, OVERSAMPLE = 16, byte 0xA5, FSM codes stepped 0001 → 0010 → 1000:
  - `start_bit`, `data_is_received` and `stop_bit` each assert.
  - After `ctrl_rx_buffer`, `rx_data` = 0xA5.
- 5-bit frame 0x15 with `number_data_receive` = 3 (clamped to 5) → `rx_data` = 0x15.
- 7E1 frame of 0x41:
  - Correct parity bit 0 → `parity_bit` = 1.
  - Flipped parity bit → `parity_bit` = 0.
- Glitch low for 4 sample ticks during start → `start_bit` stays 0, `data_is_avail` drops, and the next valid frame is received correctly.
- Two stop bits with the second held low (code 1001) → `stop_bit` = 1 in stop0, 0 in stop1.
- Reset asserted mid data bit 3 → all outputs 0 immediately; a following frame of 0x3C is received correctly.
